// File: rtl/alu_pkg.sv
// Shared ALU datapath definitions.
//   DATA_W       : datapath operand width
//   CLA_GROUP    : bits per first-level carry-lookahead block
//   sub_result_t : subtractor result bundle (difference plus flags); the ALU
//                  result mux uses the same bundle.
package alu_pkg;

  localparam int DATA_W    = 16;
  localparam int CLA_GROUP = 4;

  typedef struct packed {
    logic [DATA_W-1:0] diff;
    logic              bout;
    logic              ovf;
    logic              zero;
  } sub_result_t;

endpackage

// File: rtl/cla_group_4bit.sv
// First-level 4-bit carry-lookahead block (purely combinational).
// Ports:
//   p, g  in  [3:0] per-bit propagate / generate
//   cin   in        carry into bit 0 of the group
//   gg    out       group generate
//   pg    out       group propagate
//   c     out [3:0] carry into each bit of the group (c[0] = cin)
module cla_group_4bit
  import alu_pkg::*;
(
  input  logic [CLA_GROUP-1:0] p,
  input  logic [CLA_GROUP-1:0] g,
  input  logic                 cin,
  output logic                 gg,
  output logic                 pg,
  output logic [CLA_GROUP-1:0] c
);

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);

  assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]);
  assign pg = &p;

endmodule

// File: rtl/cla_subtractor_16bit_pipe.sv
// Two-stage pipelined carry-lookahead subtractor: diff = a - b - bin.
// Computed as a + ~b + ~bin. Stage 1 registers the per-bit and per-group
// propagate/generate terms. Stage 2 resolves the group carries and the
// in-group carries and registers the difference and flags.
// Both sides use valid/ready handshakes, so the front end can stall it.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    operand handshake
//   a, b, bin            minuend, subtrahend, borrow-in
//   out_valid/out_ready  result handshake
//   diff                 a - b - bin modulo 2^WIDTH
//   bout                 borrow-out (unsigned a < b + bin)
//   ovf                  signed overflow
//   zero                 diff == 0
// GROUP must equal CLA_GROUP because the group block is fixed at 4 bits.
module cla_subtractor_16bit_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int GROUP = CLA_GROUP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int NG  = WIDTH / GROUP;
  localparam int MSB = WIDTH - 1;

  // Operand signs differ exactly when the MSB propagate term (a ^ ~b) is 0.
  // Overflow occurs when the result sign then differs from the sign of a.
  function automatic logic calc_ovf(input logic p_msb, input logic a_msb,
                                    input logic d_msb);
    return ~p_msb & (d_msb ^ a_msb);
  endfunction

  logic              vld_p1, vld_p2;
  logic              s2_load;
  logic [WIDTH-1:0]  p_c, g_c, nb_c;
  logic [NG-1:0]     gg_c, pg_c;
  logic [WIDTH-1:0]  p_p1, g_p1;
  logic [NG-1:0]     gg_p1, pg_p1;
  logic              c0_p1, amsb_p1;
  logic [NG:0]       gen_c;
  logic [NG:0]       cg_c;
  logic              term_c;
  logic [WIDTH-1:0]  carry_c, diff_c;
  logic [NG-1:0]     gg_unused, pg_unused;
  sub_result_t       res_p2;

  assign s2_load   = ~vld_p2 | out_ready;
  assign in_ready  = ~vld_p1 | s2_load;
  assign out_valid = vld_p2;
  assign diff      = res_p2.diff;
  assign bout      = res_p2.bout;
  assign ovf       = res_p2.ovf;
  assign zero      = res_p2.zero;

  // ---- stage 0 -> p1: per-bit and per-group propagate/generate ----
  always_comb begin
    nb_c = ~b;
    p_c  = a ^ nb_c;
    g_c  = a & nb_c;
    gg_c = '0;
    pg_c = '1;
    for (int k = 0; k < NG; k++) begin
      for (int i = 0; i < GROUP; i++) begin
        gg_c[k] = g_c[k*GROUP+i] | (p_c[k*GROUP+i] & gg_c[k]);
        pg_c[k] = pg_c[k] & p_c[k*GROUP+i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else if (in_ready) begin
      vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid & in_ready) begin
      p_p1    <= p_c;
      g_p1    <= g_c;
      gg_p1   <= gg_c;
      pg_p1   <= pg_c;
      c0_p1   <= ~bin;
      amsb_p1 <= a[MSB];
    end
  end

  // ---- p1 -> p2: second-level lookahead, in-group carries, flags ----
  // Sum-of-products form: carry into group k+1 is generated by some group j
  // (or c0) and propagated through every group from j up to k.
  always_comb begin
    gen_c  = {gg_p1, c0_p1};
    cg_c   = '0;
    term_c = 1'b0;
    cg_c[0] = c0_p1;
    for (int k = 0; k < NG; k++) begin
      for (int j = 0; j <= k + 1; j++) begin
        term_c = gen_c[j];
        for (int m = j; m <= k; m++) begin
          term_c = term_c & pg_p1[m];
        end
        cg_c[k+1] = cg_c[k+1] | term_c;
      end
    end
  end

  for (genvar k = 0; k < NG; k++) begin : g_grp
    cla_group_4bit u_grp (
      .p   (p_p1[k*GROUP +: GROUP]),
      .g   (g_p1[k*GROUP +: GROUP]),
      .cin (cg_c[k]),
      .gg  (gg_unused[k]),
      .pg  (pg_unused[k]),
      .c   (carry_c[k*GROUP +: GROUP])
    );
  end

  assign diff_c = p_p1 ^ carry_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2 <= 1'b0;
      res_p2 <= '0;
    end else begin
      if (s2_load) begin
        vld_p2 <= vld_p1;
      end
      if (vld_p1 & s2_load) begin
        res_p2.diff <= diff_c;
        res_p2.bout <= ~cg_c[NG];
        res_p2.ovf  <= calc_ovf(p_p1[MSB], amsb_p1, diff_c[MSB]);
        res_p2.zero <= ~|diff_c;
      end
    end
  end

endmodule

// File: tb/tb_cla_subtractor_16bit_pipe.sv
module tb_cla_subtractor_16bit_pipe;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, bin, out_valid, out_ready;
  logic        bout, ovf, zero;
  logic [15:0] a, b, diff;
  int          nvec = 0;
  int          nmis = 0;

  always #5 clk = ~clk;

  cla_subtractor_16bit_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf),
    .zero      (zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: {diff, bout, ovf, zero} from plain 17-bit arithmetic.
  function automatic logic [18:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic bi);
    logic [16:0] t;
    logic        o;
    t = {1'b0, x} - {1'b0, y} - {16'b0, bi};
    o = (x[15] != y[15]) && (t[15] != x[15]);
    return {t[15:0], t[16], o, (t[15:0] == 16'h0)};
  endfunction

  function automatic logic [18:0] obs_res();
    return {diff, bout, ovf, zero};
  endfunction

  // Single beat with a hand-computed expected result; checks the 2-cycle latency.
  task automatic do_vec(input string tag, input logic [15:0] x, input logic [15:0] y,
                        input logic bi, input logic [18:0] exp);
    a = x; b = y; bin = bi; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "_vld_lat1"}, out_valid, 0);
    @(posedge clk); #1;
    chk({tag, "_vld_lat2"}, out_valid, 1);
    chk(tag, obs_res(), exp);
    @(posedge clk); #1;
    chk({tag, "_drained"}, out_valid, 0);
  endtask

  // mode 0: always ready; mode 1: out_ready low in cycles 2..5; mode 2: random both sides.
  task automatic run_stream(input string tag, input int nbeats, input int mode);
    logic [15:0] qa[$], qb[$];
    logic        qbi[$];
    logic [18:0] expq[$];
    logic [18:0] held, obs;
    logic        held_v, acc, drn;
    int          cyc, ndrain, first, last;
    held_v = 1'b0; held = '0; cyc = 0; ndrain = 0; first = -1; last = -1;
    for (int i = 0; i < nbeats; i++) begin
      if (mode == 2) begin
        qa.push_back(16'($urandom)); qb.push_back(16'($urandom)); qbi.push_back(1'($urandom));
      end else begin
        qa.push_back(16'(16'h1000 * i + 3 * i + 1));
        qb.push_back(16'(16'h0123 * i));
        qbi.push_back(1'(i));
      end
    end
    while ((qa.size() > 0 || expq.size() > 0) && cyc < 4 * nbeats + 50) begin
      if (mode == 1)      out_ready = !(cyc >= 2 && cyc <= 5);
      else if (mode == 2) out_ready = ($urandom_range(0, 3) != 0);
      else                out_ready = 1'b1;
      if (qa.size() > 0) begin
        in_valid = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
        a = qa[0]; b = qb[0]; bin = qbi[0];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      obs = obs_res();
      if (mode == 1 && cyc >= 2 && cyc <= 5) chk({tag, "_in_ready_full"}, in_ready, 0);
      if (held_v) chk({tag, "_stable"}, obs, held);
      held_v = out_valid & ~out_ready;
      held   = obs;
      acc = in_valid & in_ready;
      drn = out_valid & out_ready;
      if (drn) begin
        if (expq.size() == 0) begin
          chk({tag, "_spurious"}, out_valid, 0);
        end else begin
          chk(tag, obs, expq.pop_front());
          ndrain++;
          if (first < 0) first = cyc;
          last = cyc;
        end
      end
      @(posedge clk); #1;
      if (acc) begin
        expq.push_back(model(qa[0], qb[0], qbi[0]));
        void'(qa.pop_front()); void'(qb.pop_front()); void'(qbi.pop_front());
      end
      cyc++;
    end
    chk({tag, "_left_over"}, 32'(expq.size() + qa.size()), 0);
    chk({tag, "_ndrain"}, ndrain, nbeats);
    if (mode == 0) chk({tag, "_consecutive"}, last - first + 1, nbeats);
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", obs_res(), 0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);

    do_vec("v_5_3",       16'h0005, 16'h0003, 1'b0, {16'h0002, 1'b0, 1'b0, 1'b0});
    do_vec("v_0_1",       16'h0000, 16'h0001, 1'b0, {16'hFFFF, 1'b1, 1'b0, 1'b0});
    do_vec("v_0_0_bin",   16'h0000, 16'h0000, 1'b1, {16'hFFFF, 1'b1, 1'b0, 1'b0});
    do_vec("v_8000_1",    16'h8000, 16'h0001, 1'b0, {16'h7FFF, 1'b0, 1'b1, 1'b0});
    do_vec("v_eq_zero",   16'h1234, 16'h1234, 1'b0, {16'h0000, 1'b0, 1'b0, 1'b1});
    do_vec("v_7fff_ffff", 16'h7FFF, 16'hFFFF, 1'b0, {16'h8000, 1'b1, 1'b1, 1'b0});
    do_vec("v_8000_8000", 16'h8000, 16'h8000, 1'b1, {16'hFFFF, 1'b1, 1'b0, 1'b0});
    do_vec("v_ffff_0",    16'hFFFF, 16'h0000, 1'b0, {16'hFFFF, 1'b0, 1'b0, 1'b0});

    run_stream("b2b", 8, 0);
    run_stream("stall", 3, 1);

    // Two beats in flight, then a one-cycle reset.
    out_ready = 1'b1; in_valid = 1'b1; a = 16'h0009; b = 16'h0002; bin = 1'b0;
    @(posedge clk); #1;
    a = 16'h0100; b = 16'h0001;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("flush_inflight", out_valid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_result", obs_res(), 0);
    chk("flush_in_ready", in_ready, 1);
    @(posedge clk); #1;
    chk("flush_s1_gone", out_valid, 0);
    do_vec("post_flush", 16'h0042, 16'h0040, 1'b1, {16'h0001, 1'b0, 1'b0, 1'b0});

    run_stream("rand", 10000, 2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
